// File: rtl/wide_serializer.sv
// rtl/wide_serializer.sv - IN_W-to-OUT_W parallel-to-serial converter with one-word hold buffer
// Streams back-to-back words with no idle beats; outputs depend only on registered state.
module wide_serializer #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(BEATS - 1);

  generate
    if (OUT_W < 1 || OUT_W > IN_W || (IN_W % OUT_W) != 0) begin : g_bad_params
      $error("wide_serializer: IN_W must be a positive multiple of OUT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [IN_W-1:0]   r_sr;
  logic [IN_W-1:0]   r_hr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_ready;

  logic              w_acc;
  logic              w_fire;
  logic              w_lastf;
  logic [IN_W-1:0]   w_shifted;

  assign w_acc   = valid_i && r_ready;
  assign w_fire  = r_valid && ready_i;
  assign w_lastf = w_fire && (r_cnt == '0);

  // The vacated end is zero-filled so no stale bits ever reach data_o.
  assign w_shifted = (LSB_FIRST != 0) ? (r_sr >> OUT_W) : (r_sr << OUT_W);

  assign valid_o = r_valid;
  assign ready_o = r_ready;
  assign last_o  = r_valid && (r_cnt == '0);
  assign data_o  = (LSB_FIRST != 0) ? r_sr[OUT_W-1:0] : r_sr[IN_W-1 -: OUT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_sr    <= '0;
      r_hr    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_sr    <= data_i;
            r_cnt   <= CNT_FIRST;
            r_state <= SHIFT;
            r_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_lastf) begin
            if (w_acc) begin
              r_sr  <= data_i;
              r_cnt <= CNT_FIRST;
            end else begin
              r_state <= EMPTY;
              r_valid <= 1'b0;
            end
          end else begin
            if (w_fire) begin
              r_sr  <= w_shifted;
              r_cnt <= r_cnt - 1'b1;
            end
            if (w_acc) begin
              r_hr    <= data_i;
              r_state <= FULL;
              r_ready <= 1'b0;
            end
          end
        end
        FULL: begin
          // The held word moves straight into the shifter on the last beat: no gap.
          if (w_lastf) begin
            r_sr    <= r_hr;
            r_cnt   <= CNT_FIRST;
            r_state <= SHIFT;
            r_ready <= 1'b1;
          end else if (w_fire) begin
            r_sr  <= w_shifted;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_serializer.sv
// tb/tb_wide_serializer.sv - three-configuration bench with a word-queue reference model
module tb_wide_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tb_data;
  logic        tb_valid;
  logic        tb_ready;

  logic [15:0] o_dout [3];
  logic        o_vo   [3];
  logic        o_ro   [3];
  logic        o_lo   [3];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  function automatic int cfg_iw(int c);
    return (c == 2) ? 8 : 16;
  endfunction
  function automatic int cfg_ow(int c);
    return (c == 0) ? 1 : (c == 1) ? 4 : 8;
  endfunction
  function automatic int cfg_lf(int c);
    return (c == 1) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int IW = (g == 2) ? 8 : 16;
    localparam int OW = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    localparam int LF = (g == 1) ? 1 : 0;
    logic [IW-1:0] din;
    logic [OW-1:0] dout;
    logic          vo, ro, lo;
    assign din       = tb_data[IW-1:0];
    assign o_dout[g] = 16'(dout);
    assign o_vo[g]   = vo;
    assign o_ro[g]   = ro;
    assign o_lo[g]   = lo;
    wide_serializer #(.IN_W(IW), .OUT_W(OW), .LSB_FIRST(LF)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .data_i (din),
      .valid_i(tb_valid),
      .ready_o(ro),
      .data_o (dout),
      .valid_o(vo),
      .ready_i(tb_ready),
      .last_o (lo)
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per configuration, a queue of expected beats and a count of words held.
  int q_beat [3][$];
  bit q_last [3][$];
  int held   [3];

  always @(negedge clk) begin
    int  iw, ow, nb, mask, w;
    bit  exp_v, exp_r, acc, fire;
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        chk($sformatf("cfg%0d reset valid_o", c), int'(o_vo[c]), 0);
        chk($sformatf("cfg%0d reset ready_o", c), int'(o_ro[c]), 1);
        chk($sformatf("cfg%0d reset last_o", c), int'(o_lo[c]), 0);
        chk($sformatf("cfg%0d reset data_o", c), int'(o_dout[c]), 0);
        q_beat[c].delete();
        q_last[c].delete();
        held[c] = 0;
      end else begin
        exp_v = held[c] > 0;
        exp_r = held[c] < 2;
        chk($sformatf("cfg%0d valid_o", c), int'(o_vo[c]), int'(exp_v));
        chk($sformatf("cfg%0d ready_o", c), int'(o_ro[c]), int'(exp_r));
        if (exp_v) begin
          chk($sformatf("cfg%0d data_o", c), int'(o_dout[c]), q_beat[c][0]);
          chk($sformatf("cfg%0d last_o", c), int'(o_lo[c]), int'(q_last[c][0]));
        end else begin
          chk($sformatf("cfg%0d idle last_o", c), int'(o_lo[c]), 0);
        end
        fire = exp_v && tb_ready;
        acc  = tb_valid && exp_r;
        if (fire) begin
          if (q_last[c][0]) held[c]--;
          void'(q_beat[c].pop_front());
          void'(q_last[c].pop_front());
        end
        if (acc) begin
          iw   = cfg_iw(c);
          ow   = cfg_ow(c);
          nb   = iw / ow;
          mask = (1 << ow) - 1;
          w    = int'(tb_data) & ((1 << iw) - 1);
          for (int b = 0; b < nb; b++) begin
            if (cfg_lf(c) != 0) q_beat[c].push_back((w >> (b * ow)) & mask);
            else                q_beat[c].push_back((w >> (iw - (b + 1) * ow)) & mask);
            q_last[c].push_back(b == nb - 1);
          end
          held[c]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    while ((o_vo[0] || o_vo[1] || o_vo[2]) && n < 200) begin
      step();
      n++;
    end
    chk("drain within budget", int'(n < 200), 1);
  endtask

  initial begin
    logic [15:0] bits;
    int          pat [7];
    int          nib [4];
    int          k;
    bit          took;

    reset    = 1'b1;
    tb_valid = 1'b0;
    tb_ready = 1'b0;
    tb_data  = '0;
    repeat (3) step();
    chk("reset ready_o", int'(o_ro[0]), 1);
    chk("reset valid_o", int'(o_vo[0]), 0);
    reset = 1'b0;
    step();

    // Single word, MSB-first serial bits.
    bits     = 16'hA5C3;
    tb_ready = 1'b1;
    tb_valid = 1'b1;
    tb_data  = 16'hA5C3;
    step();
    tb_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1 bit %0d", i), int'(o_dout[0]), int'(bits[15-i]));
      chk($sformatf("t1 last %0d", i), int'(o_lo[0]), int'(i == 15));
      step();
    end
    chk("t1 idle after word", int'(o_vo[0]), 0);

    // Two words back to back: 32 beats, ready_o low while the second sits in HR.
    wait_idle();
    tb_valid = 1'b1;
    tb_data  = 16'hA5C3;
    step();
    tb_data  = 16'h0F0F;
    step();
    tb_valid = 1'b0;
    for (int c = 2; c <= 32; c++) begin
      chk($sformatf("t2 valid c%0d", c), int'(o_vo[0]), 1);
      chk($sformatf("t2 ready c%0d", c), int'(o_ro[0]), int'(c >= 17));
      step();
    end
    chk("t2 idle after 32 beats", int'(o_vo[0]), 0);

    // LSB-first nibbles under backpressure.
    wait_idle();
    pat      = '{1, 0, 0, 1, 1, 0, 1};
    nib      = '{4, 3, 2, 1};
    tb_ready = 1'b0;
    tb_valid = 1'b1;
    tb_data  = 16'h1234;
    step();
    tb_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      tb_ready = pat[i][0];
      chk($sformatf("t3 nibble cyc%0d", i), int'(o_dout[1]), nib[k]);
      chk($sformatf("t3 last cyc%0d", i), int'(o_lo[1]), int'(k == 3));
      if (pat[i] != 0) k++;
      step();
    end
    chk("t3 done", int'(o_vo[1]), 0);

    // FULL with long stall; third word must be refused.
    wait_idle();
    tb_ready = 1'b0;
    tb_valid = 1'b1;
    tb_data  = 16'hBEEF;
    step();
    tb_data  = 16'h6A17;
    step();
    tb_data  = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      chk("t4 ready_o low", int'(o_ro[0]), 0);
      chk("t4 valid_o high", int'(o_vo[0]), 1);
      chk("t4 data held", int'(o_dout[0]), 1);
      step();
    end
    wait_idle();

    // Reset mid-word with HR full.
    tb_valid = 1'b1;
    tb_data  = 16'hA5C3;
    step();
    tb_data  = 16'h1234;
    step();
    tb_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("t5 reset valid_o", int'(o_vo[0]), 0);
    chk("t5 reset data_o", int'(o_dout[0]), 0);
    chk("t5 reset ready_o", int'(o_ro[0]), 1);
    step();
    step();
    reset    = 1'b0;
    tb_valid = 1'b1;
    tb_data  = 16'hFFFF;
    step();
    tb_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5 ones %0d", i), int'(o_dout[0]), 1);
      step();
    end
    chk("t5 idle after ones", int'(o_vo[0]), 0);

    // BEATS == 1 stream with random backpressure.
    wait_idle();
    for (int w = 1; w <= 4; w++) begin
      tb_valid = 1'b1;
      tb_data  = 16'(w);
      took     = 1'b0;
      for (int n = 0; n < 50 && !took; n++) begin
        tb_ready = 1'($urandom_range(0, 1));
        if (o_vo[2]) chk("t6 every beat is last", int'(o_lo[2]), 1);
        took = o_ro[2];
        step();
      end
      chk($sformatf("t6 word %0d accepted", w), int'(took), 1);
    end
    wait_idle();

    // Random traffic on all configurations, with one reset pulse midway.
    for (int i = 0; i < 3000; i++) begin
      tb_valid = ($urandom_range(0, 3) != 0);
      tb_ready = ($urandom_range(0, 3) != 0);
      tb_data  = 16'($urandom);
      reset    = (i == 1500);
      step();
    end
    reset = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
